rom_loader: RTL

Boot-time copier that sits directly downstream of the asynchronous-read ROM.
- Drives the ROM address, consumes the ROM data word and writes LENGTH words into main memory starting at BASE_ADDR, over a valid/ready write port.
- Used to preload the LC-3 program/OS image before the CPU is released from hold; `busy` keeps the CPU stalled and `done` releases it.

---
 rtl/rom_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Boot-time copier: streams LENGTH words from an async-read ROM into main memory
// at BASE_ADDR over a valid/ready write port, holding the CPU via busy until done.
module rom_loader #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int LENGTH         = 256,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = 16'h3000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic [ROM_ADDR_WIDTH:0]   count
);

  // One extra bit so a full-ROM copy (LENGTH = 2^ROM_ADDR_WIDTH) can be counted.
  localparam int IW = ROM_ADDR_WIDTH + 1;
  localparam bit EMPTY = (LENGTH == 0);
  localparam logic [IW-1:0] LAST = EMPTY ? '0 : IW'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                    state, state_n;
  logic [IW-1:0]             index, index_n;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_n;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0]     mem_wdata_n;
  logic [IW-1:0]             count_n;

  // NOTE: state registers use non-blocking (<=) so every register samples the
  // pre-edge values computed below, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      rom_addr  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      index     <= index_n;
      rom_addr  <= rom_addr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      count     <= count_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    state_n     = state;
    index_n     = index;
    rom_addr_n  = rom_addr;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    count_n     = count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          count_n = '0;
          if (EMPTY) begin
            state_n = DONE;
          end else begin
            state_n    = READ;
            index_n    = '0;
            rom_addr_n = '0;
          end
        end
      end
      READ: begin
        mem_wdata_n = rom_data;
        // Address wraps silently past the top of memory.
        mem_addr_n  = BASE_ADDR + MEM_ADDR_WIDTH'(index);
        state_n     = WRITE;
      end
      WRITE: begin
        if (mem_ready) begin
          count_n = count + 1'b1;
          index_n = index + 1'b1;
          if (index == LAST) begin
            state_n = DONE;
          end else begin
            state_n    = READ;
            rom_addr_n = ROM_ADDR_WIDTH'(index + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state == READ) || (state == WRITE);
  assign done   = (state == DONE);
  assign mem_we = (state == WRITE);

endmodule
